// File: rtl/bsg_acm_pkg.sv
// Shared sizing helpers and packet-layout constants for the ACM input path.
// Build option: BSG_ACM_INPUT_CHECKSUM_EN adds one XOR trailer beat per packet.
package bsg_acm_pkg;

  // Width needed to index x values, never less than one bit.
  function automatic int acm_safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  // Ceiling division for beat counts.
  function automatic int acm_cdiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bits needed to carry any iteration count 0..max_len.
  function automatic int acm_iter_width(input int max_len);
    return acm_safe_clog2(max_len + 1);
  endfunction

  // Total packet payload: pixel bits plus the iteration field.
  function automatic int acm_payload_width(input int board, input int pixel, input int max_len);
    return board * board * pixel + acm_iter_width(max_len);
  endfunction

  // Number of data beats needed to carry one payload.
  function automatic int acm_data_beats(input int payload, input int link);
    return acm_cdiv(payload, link);
  endfunction

  // The iteration count sits at the bottom of beat 0; pixels follow directly above.
  localparam int acm_iter_lsb_gp = 0;

  function automatic int acm_pix_lsb(input int max_len);
    return acm_iter_lsb_gp + acm_iter_width(max_len);
  endfunction

  // Trailer beats appended per packet; a trailer is one full link beat wide.
`ifdef BSG_ACM_INPUT_CHECKSUM_EN
  localparam int acm_chk_beats_gp = 1;
`else
  localparam int acm_chk_beats_gp = 0;
`endif

  // What happens to an assembled packet in a given cycle.
  typedef enum logic [1:0] {
    ACM_XFER_NONE = 2'd0,
    ACM_XFER_LOAD = 2'd1,
    ACM_XFER_DROP = 2'd2
  } acm_xfer_e;

endpackage

// File: rtl/bsg_acm_beat_assembler.sv
// Collects link beats into one packet buffer and flags it full when complete.
// Build option: BSG_ACM_INPUT_CHECKSUM_EN adds a running XOR checked against a trailer beat.
module bsg_acm_beat_assembler
  import bsg_acm_pkg::*;
#(
  parameter int link_width_p = 64,
  parameter int beats_p      = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [link_width_p-1:0]           data_i,
  input  logic                              v_i,
  output logic                              ready_o,
  output logic                              full_o,
  output logic [beats_p*link_width_p-1:0]   data_o,
  output logic                              chk_ok_o,
  input  logic                              yumi_i
);

  localparam int total_beats_lp = beats_p + acm_chk_beats_gp;
  localparam int cnt_width_lp   = acm_safe_clog2(total_beats_lp);
  localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(total_beats_lp - 1);

  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                    full_q, full_d;
  logic                    rst_hold_q;
  logic [link_width_p-1:0] slot_q [beats_p];
  logic                    accept;
  logic                    last_beat;

  // Hold off the link while in reset and for the first cycle after it.
  assign ready_o   = ~full_q & ~reset_i & ~rst_hold_q;
  assign accept    = v_i & ready_o;
  assign last_beat = (cnt_q == last_cnt_lp);
  assign full_o    = full_q;

  // Next state for the beat counter and the full flag.
  always_comb begin
    cnt_d  = cnt_q;
    full_d = full_q;
    if (accept) begin
      cnt_d = last_beat ? '0 : cnt_q + cnt_width_lp'(1);
    end
    // Full is only ever set while not full (ready_o is low when full), so
    // clearing and setting never collide.
    if (full_q && yumi_i) begin
      full_d = 1'b0;
    end else if (accept && last_beat) begin
      full_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i) begin
    rst_hold_q <= reset_i;
    if (reset_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Slot write: the counter selects which beat slot captures the incoming data.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < beats_p; i++) begin
      if (accept && (cnt_q == cnt_width_lp'(i))) begin
        slot_q[i] <= data_i;
      end
    end
  end

  for (genvar g = 0; g < beats_p; g++) begin : g_pack
    assign data_o[g*link_width_p +: link_width_p] = slot_q[g];
  end

`ifdef BSG_ACM_INPUT_CHECKSUM_EN
  logic [link_width_p-1:0] xor_q, xor_d;
  logic                    chk_ok_q, chk_ok_d;

  // Running XOR restarts on beat 0 and is compared against the trailer beat.
  always_comb begin
    xor_d    = xor_q;
    chk_ok_d = chk_ok_q;
    if (accept) begin
      if (last_beat) begin
        chk_ok_d = (xor_q == data_i);
      end else if (cnt_q == '0) begin
        xor_d = data_i;
      end else begin
        xor_d = xor_q ^ data_i;
      end
    end
  end

  // Checksum datapath registers.
  always_ff @(posedge clk_i) begin
    xor_q    <= xor_d;
    chk_ok_q <= chk_ok_d;
  end

  assign chk_ok_o = chk_ok_q;
`else
  assign chk_ok_o = 1'b1;
`endif

endmodule

// File: rtl/bsg_acm_input_deserializer.sv
// Input deserializer for the ACM encryptor: assembles link beats into
// {pixels, iters}, range-checks the count and hands it to a registered output.
// Build option: BSG_ACM_INPUT_CHECKSUM_EN enables the XOR trailer check.
module bsg_acm_input_deserializer
  import bsg_acm_pkg::*;
#(
  parameter int link_width_p      = 64,
  parameter int board_width_p     = 8,
  parameter int pixel_width_p     = 1,
  parameter int max_game_length_p = 255
) (
  input  logic                                                 clk_i,
  input  logic                                                 reset_i,
  input  logic [link_width_p-1:0]                              data_i,
  input  logic                                                 v_i,
  output logic                                                 ready_o,
  output logic [board_width_p*board_width_p*pixel_width_p-1:0] data_o,
  output logic [acm_iter_width(max_game_length_p)-1:0]         iters_o,
  output logic                                                 v_o,
  input  logic                                                 ready_i,
  output logic                                                 err_o
);

  localparam int pix_width_lp  = board_width_p * board_width_p * pixel_width_p;
  localparam int iter_width_lp = acm_iter_width(max_game_length_p);
  localparam int payload_lp    = acm_payload_width(board_width_p, pixel_width_p, max_game_length_p);
  localparam int beats_lp      = acm_data_beats(payload_lp, link_width_p);
  localparam int asm_width_lp  = beats_lp * link_width_p;

  logic [asm_width_lp-1:0]  asm_data;
  logic                     asm_full;
  logic                     asm_chk_ok;
  logic                     asm_yumi;
  logic [iter_width_lp-1:0] asm_iters;
  logic [pix_width_lp-1:0]  asm_pix;
  logic [31:0]              asm_iters_ext;
  logic                     range_ok;

  bsg_acm_beat_assembler #(
    .link_width_p (link_width_p),
    .beats_p      (beats_lp)
  ) assembler (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .data_i   (data_i),
    .v_i      (v_i),
    .ready_o  (ready_o),
    .full_o   (asm_full),
    .data_o   (asm_data),
    .chk_ok_o (asm_chk_ok),
    .yumi_i   (asm_yumi)
  );

  assign asm_iters = asm_data[acm_iter_lsb_gp +: iter_width_lp];
  assign asm_pix   = asm_data[acm_pix_lsb(max_game_length_p) +: pix_width_lp];

  // Padding MSBs of the final beat carry no information.
  if (asm_width_lp > payload_lp) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^asm_data[asm_width_lp-1:payload_lp];
  end

  // Compare at 32 bits so a field that cannot exceed the limit still elaborates cleanly.
  assign asm_iters_ext = 32'(asm_iters);
  assign range_ok      = (asm_iters_ext <= 32'(max_game_length_p));

  acm_xfer_e                xfer;
  logic                     out_v_q, out_v_d;
  logic                     err_q, err_d;
  logic [pix_width_lp-1:0]  data_q;
  logic [iter_width_lp-1:0] iters_q;

  // Transfer decision: a complete packet leaves assembly once the output stage
  // is empty or draining this cycle; faulty packets are discarded instead of loaded.
  always_comb begin
    xfer = ACM_XFER_NONE;
    if (asm_full && (!out_v_q || ready_i)) begin
      xfer = (range_ok && asm_chk_ok) ? ACM_XFER_LOAD : ACM_XFER_DROP;
    end
    asm_yumi = (xfer != ACM_XFER_NONE);
    out_v_d  = (xfer == ACM_XFER_LOAD) || (out_v_q && !ready_i);
    err_d    = (xfer == ACM_XFER_DROP);
  end

  // Output-stage control registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_v_q <= out_v_d;
      err_q   <= err_d;
    end
  end

  // Output-stage data: only overwritten by a load, so it holds through a stall.
  always_ff @(posedge clk_i) begin
    if (xfer == ACM_XFER_LOAD) begin
      data_q  <= asm_pix;
      iters_q <= asm_iters;
    end
  end

  assign v_o     = out_v_q;
  assign err_o   = err_q;
  assign data_o  = data_q;
  assign iters_o = iters_q;

endmodule

// File: tb/tb_bsg_acm_input_deserializer.sv
module tb_bsg_acm_input_deserializer;

  // DUT A: 64-bit link, 8x8x1 board, limit 200 -> 8-bit iters, 72-bit payload, 2 beats.
  // DUT B: 16-bit link, 4x4x4 board, limit 255 -> 8-bit iters, 72-bit payload, 5 beats.
  localparam int A_BEATS = 2;
  localparam int B_BEATS = 5;
`ifdef BSG_ACM_INPUT_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct packed {
    logic [63:0] pix;
    logic [7:0]  it;
  } pkt_t;

  logic        clk;
  logic        rst_a, rst_b;
  logic [63:0] a_data;
  logic        a_v, a_ready, a_v_o, a_rdy, a_err;
  logic [63:0] a_data_o;
  logic [7:0]  a_iters_o;
  logic [15:0] b_data;
  logic        b_v, b_ready, b_v_o, b_rdy, b_err;
  logic [63:0] b_data_o;
  logic [7:0]  b_iters_o;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  pkt_t qa[$];
  pkt_t qb[$];

  bsg_acm_input_deserializer #(
    .link_width_p(64), .board_width_p(8), .pixel_width_p(1), .max_game_length_p(200)
  ) dut_a (
    .clk_i(clk), .reset_i(rst_a), .data_i(a_data), .v_i(a_v), .ready_o(a_ready),
    .data_o(a_data_o), .iters_o(a_iters_o), .v_o(a_v_o), .ready_i(a_rdy), .err_o(a_err)
  );

  bsg_acm_input_deserializer #(
    .link_width_p(16), .board_width_p(4), .pixel_width_p(4), .max_game_length_p(255)
  ) dut_b (
    .clk_i(clk), .reset_i(rst_b), .data_i(b_data), .v_i(b_v), .ready_o(b_ready),
    .data_o(b_data_o), .iters_o(b_iters_o), .v_o(b_v_o), .ready_i(b_rdy), .err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_beat_a(input logic [63:0] d);
    int guard = 0;
    a_data = d;
    a_v    = 1'b1;
    @(negedge clk);
    while (!a_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_vec++; n_err++;
      $display("FAIL beat_a_timeout: ready_o stayed %b, want 1", a_ready);
    end
    @(posedge clk); #1;
    a_v = 1'b0;
  endtask

  task automatic send_beat_b(input logic [15:0] d);
    int guard = 0;
    b_data = d;
    b_v    = 1'b1;
    @(negedge clk);
    while (!b_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      n_vec++; n_err++;
      $display("FAIL beat_b_timeout: ready_o stayed %b, want 1", b_ready);
    end
    @(posedge clk); #1;
    b_v = 1'b0;
  endtask

  // Packet = {pixels, iters} LSB-first; unused final-beat MSBs filled with junk.
  task automatic send_pkt_a(input logic [63:0] pix, input logic [7:0] it);
    logic [127:0] raw;
    raw = {$urandom(), $urandom(), $urandom(), $urandom()};
    raw[71:0] = {pix, it};
    for (int i = 0; i < A_BEATS; i++) send_beat_a(raw[i*64 +: 64]);
`ifdef BSG_ACM_INPUT_CHECKSUM_EN
    send_beat_a(raw[63:0] ^ raw[127:64]);
`endif
  endtask

  task automatic send_pkt_b(input logic [63:0] pix, input logic [7:0] it);
    logic [79:0] raw;
    logic [15:0] chk;
    raw = 80'({$urandom(), $urandom(), $urandom()});
    raw[71:0] = {pix, it};
    chk = '0;
    for (int i = 0; i < B_BEATS; i++) begin
      send_beat_b(raw[i*16 +: 16]);
      chk ^= raw[i*16 +: 16];
    end
`ifdef BSG_ACM_INPUT_CHECKSUM_EN
    send_beat_b(chk);
`else
    if (chk === 16'hx) $display("note: unknown beat data");
`endif
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    a_v = 1'b0; b_v = 1'b0; a_rdy = 1'b0; b_rdy = 1'b0;
    a_data = '0; b_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_a: got %b want 0", a_ready); end
    n_vec++; if (a_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_a: got %b want 0", a_v_o); end
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL reset_err_a: got %b want 0", a_err); end
    n_vec++; if (b_ready !== 1'b0 || b_v_o !== 1'b0 || b_err !== 1'b0) begin
      n_err++; $display("FAIL reset_b: ready %b v %b err %b want 0 0 0", b_ready, b_v_o, b_err);
    end
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0 || a_v_o !== 1'b0) begin
      n_err++; $display("FAIL post_reset_a: ready %b v %b want 0 0", a_ready, a_v_o);
    end
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_reset_a: got %b want 1", a_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    logic [63:0] pix = 64'hA5C3_0F1E_7788_9911;
    a_rdy = 1'b1;
    send_pkt_a(pix, 8'd5);
    @(negedge clk);
    n_vec++; if (a_v_o !== 1'b0) begin n_err++; $display("FAIL lat_early_v: got %b want 0", a_v_o); end
    @(negedge clk);
    n_vec++; if (a_v_o !== 1'b1) begin n_err++; $display("FAIL lat_v: got %b want 1", a_v_o); end
    n_vec++; if (a_iters_o !== 8'd5) begin n_err++; $display("FAIL lat_iters: got %0d want 5", a_iters_o); end
    n_vec++; if (a_data_o !== pix) begin n_err++; $display("FAIL lat_data: got %h want %h", a_data_o, pix); end
    @(negedge clk);
    n_vec++; if (a_v_o !== 1'b0) begin n_err++; $display("FAIL lat_v_width: got %b want 0", a_v_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    pkt_t p[3];
    for (int i = 0; i < 3; i++) begin
      p[i].pix = {$urandom(), $urandom()};
      p[i].it  = 8'($urandom_range(0, 200));
    end
    a_rdy = 1'b0;
    qa.push_back(p[0]); send_pkt_a(p[0].pix, p[0].it);
    qa.push_back(p[1]); send_pkt_a(p[1].pix, p[1].it);
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", a_ready); end
    fork
      begin
        qa.push_back(p[2]);
        send_pkt_a(p[2].pix, p[2].it);
      end
      begin
        int got = 0;
        int guard = 0;
        pkt_t e;
        repeat (3) begin
          @(negedge clk);
          n_vec++;
          if (a_v_o !== 1'b1 || a_data_o !== p[0].pix || a_iters_o !== p[0].it) begin
            n_err++; $display("FAIL bp_hold: v %b data %h iters %0d want 1 %h %0d", a_v_o, a_data_o, a_iters_o, p[0].pix, p[0].it);
          end
        end
        @(posedge clk); #1;
        a_rdy = 1'b1;
        while (got < 3 && guard < 80) begin
          @(negedge clk);
          guard++;
          if (a_v_o === 1'b1) begin
            n_vec++;
            if (qa.size() == 0) begin
              n_err++; $display("FAIL bp_extra: unexpected packet %h", a_data_o);
            end else begin
              e = qa.pop_front();
              if ({a_data_o, a_iters_o} !== {e.pix, e.it}) begin
                n_err++; $display("FAIL bp_order: got %h/%0d want %h/%0d", a_data_o, a_iters_o, e.pix, e.it);
              end
            end
            got++;
          end
        end
        if (got < 3) begin n_vec++; n_err++; $display("FAIL bp_timeout: got %0d packets want 3", got); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_range();
    int ecnt = 0;
    int vcnt = 0;
    logic [63:0] pix = 64'h0123_4567_89AB_CDEF;
    logic [63:0] seen = '0;
    logic [7:0]  seen_it = '0;
    a_rdy = 1'b1;
    send_pkt_a(64'hDEAD_BEEF_0000_FFFF, 8'd201);
    repeat (6) begin
      @(negedge clk);
      if (a_err === 1'b1) ecnt++;
      if (a_v_o === 1'b1) vcnt++;
    end
    n_vec++; if (ecnt != 1) begin n_err++; $display("FAIL range_err_pulse: got %0d cycles want 1", ecnt); end
    n_vec++; if (vcnt != 0) begin n_err++; $display("FAIL range_dropped: v_o high %0d cycles want 0", vcnt); end
    @(posedge clk); #1;
    ecnt = 0; vcnt = 0;
    send_pkt_a(pix, 8'd200);
    repeat (6) begin
      @(negedge clk);
      if (a_err === 1'b1) ecnt++;
      if (a_v_o === 1'b1) begin vcnt++; seen = a_data_o; seen_it = a_iters_o; end
    end
    n_vec++; if (vcnt != 1 || ecnt != 0) begin n_err++; $display("FAIL range_limit_ok: v %0d err %0d want 1 0", vcnt, ecnt); end
    n_vec++; if (seen !== pix || seen_it !== 8'd200) begin
      n_err++; $display("FAIL range_limit_data: got %h/%0d want %h/200", seen, seen_it, pix);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int vcnt = 0;
    logic [63:0] pix = 64'hFEDC_BA98_7654_3210;
    logic [63:0] seen = '0;
    logic [7:0]  seen_it = '0;
    a_rdy = 1'b1;
    send_beat_a(64'hFFFF_FFFF_FFFF_FF77);
    rst_a = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", a_ready); end
      @(posedge clk); #1;
    end
    rst_a = 1'b0;
    @(negedge clk);
    n_vec++; if (a_ready !== 1'b0 || a_v_o !== 1'b0 || a_err !== 1'b0) begin
      n_err++; $display("FAIL midrst_after: ready %b v %b err %b want 0 0 0", a_ready, a_v_o, a_err);
    end
    @(posedge clk); #1;
    send_pkt_a(pix, 8'd17);
    repeat (6) begin
      @(negedge clk);
      if (a_v_o === 1'b1) begin vcnt++; seen = a_data_o; seen_it = a_iters_o; end
    end
    n_vec++; if (vcnt != 1 || seen !== pix || seen_it !== 8'd17) begin
      n_err++; $display("FAIL midrst_clean: v %0d data %h iters %0d want 1 %h 17", vcnt, seen, seen_it, pix);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    a_rdy = 1'b1;
    fork
      begin
        pkt_t p;
        for (int i = 0; i < 4; i++) begin
          p.pix = {$urandom(), $urandom()};
          p.it  = 8'($urandom_range(0, 200));
          qa.push_back(p);
          send_pkt_a(p.pix, p.it);
        end
      end
      begin
        int got = 0;
        int guard = 0;
        int last = 0;
        pkt_t e;
        while (got < 4 && guard < 100) begin
          @(negedge clk);
          guard++;
          if (a_v_o === 1'b1) begin
            n_vec++;
            e = qa.pop_front();
            if ({a_data_o, a_iters_o} !== {e.pix, e.it}) begin
              n_err++; $display("FAIL b2b_data: got %h/%0d want %h/%0d", a_data_o, a_iters_o, e.pix, e.it);
            end
            if (got > 0) begin
              n_vec++;
              if (cyc - last != A_BEATS + CHK + 1) begin
                n_err++; $display("FAIL b2b_rate: spacing %0d want %0d", cyc - last, A_BEATS + CHK + 1);
              end
            end
            last = cyc;
            got++;
          end
        end
        if (got < 4) begin n_vec++; n_err++; $display("FAIL b2b_timeout: got %0d want 4", got); end
      end
    join
    @(posedge clk); #1;
  endtask

  task automatic test_random_stall();
    b_rdy = 1'b0;
    fork
      begin
        pkt_t p;
        for (int i = 0; i < 12; i++) begin
          p.pix = {$urandom(), $urandom()};
          p.it  = 8'($urandom_range(0, 255));
          qb.push_back(p);
          send_pkt_b(p.pix, p.it);
        end
      end
      begin
        int got = 0;
        int guard = 0;
        bit stalled = 1'b0;
        logic [63:0] hd = '0;
        logic [7:0]  hi = '0;
        pkt_t e;
        while (got < 12 && guard < 3000) begin
          @(negedge clk);
          guard++;
          if (b_err === 1'b1) begin n_vec++; n_err++; $display("FAIL rnd_err: err_o %b want 0", b_err); end
          if (stalled) begin
            n_vec++;
            if (b_v_o !== 1'b1 || b_data_o !== hd || b_iters_o !== hi) begin
              n_err++; $display("FAIL rnd_stable: v %b %h/%0d want 1 %h/%0d", b_v_o, b_data_o, b_iters_o, hd, hi);
            end
          end
          if (b_v_o === 1'b1 && b_rdy === 1'b1) begin
            n_vec++;
            if (qb.size() == 0) begin
              n_err++; $display("FAIL rnd_extra: unexpected packet %h", b_data_o);
            end else begin
              e = qb.pop_front();
              if ({b_data_o, b_iters_o} !== {e.pix, e.it}) begin
                n_err++; $display("FAIL rnd_data: got %h/%0d want %h/%0d", b_data_o, b_iters_o, e.pix, e.it);
              end
            end
            got++;
          end
          stalled = (b_v_o === 1'b1) && (b_rdy === 1'b0);
          hd = b_data_o;
          hi = b_iters_o;
          @(posedge clk); #1;
          b_rdy = 1'($urandom_range(0, 1));
        end
        if (got < 12) begin n_vec++; n_err++; $display("FAIL rnd_timeout: got %0d want 12", got); end
      end
    join
    b_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

`ifdef BSG_ACM_INPUT_CHECKSUM_EN
  task automatic test_checksum();
    logic [63:0] b0, b1;
    int ecnt, vcnt;
    logic [63:0] seen;
    a_rdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b0 = {$urandom(), $urandom()};
      b1 = {$urandom(), $urandom()};
      b0[7:0] = 8'd42;
      send_beat_a(b0);
      send_beat_a(b1);
      send_beat_a((k == 1) ? (b0 ^ b1 ^ 64'd1) : (b0 ^ b1));
      ecnt = 0; vcnt = 0; seen = '0;
      repeat (6) begin
        @(negedge clk);
        if (a_err === 1'b1) ecnt++;
        if (a_v_o === 1'b1) begin vcnt++; seen = a_data_o; end
      end
      n_vec++;
      if (k == 1) begin
        if (ecnt != 1 || vcnt != 0) begin n_err++; $display("FAIL chk_bad: err %0d v %0d want 1 0", ecnt, vcnt); end
      end else begin
        if (ecnt != 0 || vcnt != 1 || seen !== {b1[7:0], b0[63:8]}) begin
          n_err++; $display("FAIL chk_good: err %0d v %0d data %h want 0 1 %h", ecnt, vcnt, seen, {b1[7:0], b0[63:8]});
        end
      end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_random_stall();
`ifdef BSG_ACM_INPUT_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
